crc_checker: RTL and testbench

CRC_CHECKER -- requirements
Module: crc_checker

---
 rtl/crc_checker_if.sv | 42 ++++
 rtl/crc_checker.sv | 179 +++++++++++++++++
 tb/tb_crc_checker.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_checker_if.sv
//------------------------------------------------------------------------------
// crc_checker_if
// Receive-side bus between a byte source (MAC/PHY front end) and crc_checker.
//
// Signals:
//   data_in      [7:0]  received byte, data then FCS bytes in wire order
//   data_valid          data_in carries a byte this cycle
//   frame_active        high for the whole frame, FCS bytes included
//   rx_err              PHY error indication, meaningful while frame_active=1
//   frame_done          one-cycle result strobe from the checker
//   crc_ok              FCS residue matched
//   len_err             frame length outside the legal window
//   phy_err             rx_err was seen during the frame
//   frame_len   [10:0]  bytes received including FCS, saturating at 2047
//
// Modports:
//   master  byte source: drives the receive inputs, observes results
//   slave   checker: consumes the receive inputs, drives results
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface crc_checker_if;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        frame_active;
   logic        rx_err;
   logic        frame_done;
   logic        crc_ok;
   logic        len_err;
   logic        phy_err;
   logic [10:0] frame_len;

   modport master (
      output data_in, data_valid, frame_active, rx_err,
      input  frame_done, crc_ok, len_err, phy_err, frame_len
   );

   modport slave (
      input  data_in, data_valid, frame_active, rx_err,
      output frame_done, crc_ok, len_err, phy_err, frame_len
   );
endinterface

// File: rtl/crc_checker.sv
//------------------------------------------------------------------------------
// crc_checker
// Checks received Ethernet-style frames: runs CRC-32 (poly 0x04C11DB7,
// MSB-first, non-reflected, one byte per cycle) over data plus FCS, counts the
// bytes and latches PHY errors. When frame_active drops, the results are
// registered and announced with a one-cycle frame_done pulse; they then hold
// until the next frame_done.
//
// Parameters:
//   MIN_LEN  minimum legal frame length in bytes, FCS included
//   MAX_LEN  maximum legal frame length in bytes, FCS included
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      crc_checker_if.slave: receive inputs and result outputs
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module crc_checker #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic          clk,
   input  logic          rst_n,
   crc_checker_if.slave  bus
);

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   // Register value left after running a correct FCS through the CRC.
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [10:0] CNT_MAX     = 11'd2047;
   localparam logic [31:0] MIN_LEN_U   = 32'(MIN_LEN);
   localparam logic [31:0] MAX_LEN_U   = 32'(MAX_LEN);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // One byte of MSB-first CRC-32: byte enters at the top, eight shift steps.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc_in ^ {data, 24'h00_0000};
      for (int i = 0; i < 8; i++) begin
         if (c[31]) begin
            c = {c[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   state_t      state_r;
   logic [31:0] crc_r;
   logic [10:0] count_r;
   logic        phy_err_acc_r;
   logic        frame_done_r;
   logic        crc_ok_r;
   logic        len_err_r;
   logic        phy_err_r;
   logic [10:0] frame_len_r;

   logic [31:0] crc_base_s;
   logic [10:0] cnt_base_s;
   logic [31:0] crc_upd_s;
   logic [10:0] cnt_inc_s;
   logic [31:0] cnt_wide_s;
   logic        res_crc_ok_s;
   logic        res_len_err_s;

   // Next CRC / count for an accepted byte; a frame starting from IDLE
   // always uses fresh seed values, whatever the registers hold.
   always_comb begin
      crc_base_s = crc_r;
      cnt_base_s = count_r;
      if (state_r == IDLE) begin
         crc_base_s = CRC_INIT;
         cnt_base_s = 11'd0;
      end else begin
         crc_base_s = crc_r;
         cnt_base_s = count_r;
      end
      crc_upd_s = crc32_byte(crc_base_s, bus.data_in);
      if (cnt_base_s == CNT_MAX) begin
         cnt_inc_s = CNT_MAX;
      end else begin
         cnt_inc_s = cnt_base_s + 11'd1;
      end
   end

   // Frame verdict from the accumulated state. Frames shorter than the FCS
   // itself can never be good, and a saturated count is always a length error
   // even if MAX_LEN were configured at or above the saturation point.
   always_comb begin
      cnt_wide_s    = {21'd0, count_r};
      res_crc_ok_s  = (count_r >= 11'd4) && (crc_r == CRC_RESIDUE);
      res_len_err_s = (cnt_wide_s < MIN_LEN_U) || (cnt_wide_s > MAX_LEN_U) ||
                      (count_r == CNT_MAX) || (count_r < 11'd4);
   end

   // Receive FSM with registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         crc_r         <= CRC_INIT;
         count_r       <= 11'd0;
         phy_err_acc_r <= 1'b0;
         frame_done_r  <= 1'b0;
         crc_ok_r      <= 1'b0;
         len_err_r     <= 1'b0;
         phy_err_r     <= 1'b0;
         frame_len_r   <= 11'd0;
      end else begin
         case (state_r)
            IDLE: begin
               frame_done_r <= 1'b0;
               if (bus.frame_active) begin
                  crc_r         <= bus.data_valid ? crc_upd_s : CRC_INIT;
                  count_r       <= bus.data_valid ? cnt_inc_s : 11'd0;
                  phy_err_acc_r <= bus.rx_err;
                  state_r       <= RECV;
               end else begin
                  crc_r         <= CRC_INIT;
                  count_r       <= 11'd0;
                  phy_err_acc_r <= 1'b0;
                  state_r       <= IDLE;
               end
            end
            RECV: begin
               if (bus.frame_active) begin
                  frame_done_r <= 1'b0;
                  if (bus.data_valid) begin
                     crc_r   <= crc_upd_s;
                     count_r <= cnt_inc_s;
                  end else begin
                     crc_r   <= crc_r;
                     count_r <= count_r;
                  end
                  if (bus.rx_err) begin
                     phy_err_acc_r <= 1'b1;
                  end else begin
                     phy_err_acc_r <= phy_err_acc_r;
                  end
                  state_r <= RECV;
               end else begin
                  // End of frame: any byte offered on this edge is dropped.
                  crc_ok_r      <= res_crc_ok_s;
                  len_err_r     <= res_len_err_s;
                  phy_err_r     <= phy_err_acc_r;
                  frame_len_r   <= count_r;
                  frame_done_r  <= 1'b1;
                  crc_r         <= CRC_INIT;
                  count_r       <= 11'd0;
                  phy_err_acc_r <= 1'b0;
                  state_r       <= IDLE;
               end
            end
            default: begin
               state_r       <= IDLE;
               crc_r         <= CRC_INIT;
               count_r       <= 11'd0;
               phy_err_acc_r <= 1'b0;
               frame_done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.frame_done = frame_done_r;
   assign bus.crc_ok     = crc_ok_r;
   assign bus.len_err    = len_err_r;
   assign bus.phy_err    = phy_err_r;
   assign bus.frame_len  = frame_len_r;

endmodule

// File: tb/tb_crc_checker.sv
//------------------------------------------------------------------------------
// tb_crc_checker
// Self-checking bench for crc_checker: a table of short fixed frames, directed
// multi-cycle sequences, and random frames compared against a bit-serial
// CRC-32 reference model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_crc_checker;

   localparam int          MIN_LEN  = 64;
   localparam int          MAX_LEN  = 1518;
   localparam logic [31:0] POLY     = 32'h04C1_1DB7;
   localparam logic [31:0] RESIDUE  = 32'hC704_DD7B;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   crc_checker_if bus ();

   crc_checker #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  frame_q [$];
   logic        got_ok, got_len_err, got_phy;
   logic [10:0] got_len;

   typedef struct {
      int          n;
      logic [7:0]  b [13];
      logic        exp_ok;
      logic        exp_len_err;
      logic [10:0] exp_len;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference CRC: plain bit-serial long division over the frame bit stream.
   function automatic logic [31:0] ref_crc();
      logic [31:0] r;
      logic        fb;
      r = 32'hFFFF_FFFF;
      foreach (frame_q[i]) begin
         for (int k = 7; k >= 0; k--) begin
            fb = r[31] ^ frame_q[i][k];
            r  = r << 1;
            if (fb) r = r ^ POLY;
         end
      end
      return r;
   endfunction

   // Random payload plus FCS (complement of running CRC, MSB byte first).
   task automatic build_frame(input int n_data, input bit good);
      logic [31:0] fcs;
      frame_q.delete();
      for (int i = 0; i < n_data; i++) frame_q.push_back(8'($urandom));
      fcs = ~ref_crc();
      if (!good) fcs = fcs ^ 32'h0000_0001;
      frame_q.push_back(fcs[31:24]);
      frame_q.push_back(fcs[23:16]);
      frame_q.push_back(fcs[15:8]);
      frame_q.push_back(fcs[7:0]);
   endtask

   // Drive frame_q as one frame, then drop frame_active for one cycle and
   // capture the result strobe. No trailing idle cycle is added.
   task automatic send_frame(input int gap_pct, input int err_idx, input bit dv_on_fall);
      int early;
      early = 0;
      bus.frame_active = 1'b1;
      if (frame_q.size() == 0) begin
         bus.data_valid = 1'b0;
         bus.rx_err     = 1'b0;
         tick();
         if (bus.frame_done) early++;
      end
      for (int i = 0; i < frame_q.size(); i++) begin
         for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
            bus.data_valid = 1'b0;
            bus.data_in    = 8'($urandom);
            bus.rx_err     = 1'b0;
            tick();
            if (bus.frame_done) early++;
         end
         bus.data_valid = 1'b1;
         bus.data_in    = frame_q[i];
         bus.rx_err     = (i == err_idx);
         tick();
         if (bus.frame_done) early++;
      end
      bus.frame_active = 1'b0;
      bus.data_valid   = dv_on_fall;
      bus.data_in      = 8'($urandom);
      bus.rx_err       = dv_on_fall;
      tick();
      chk("no_early_done", early, 0);
      chk("done_pulse", bus.frame_done, 1);
      got_ok      = bus.crc_ok;
      got_len_err = bus.len_err;
      got_phy     = bus.phy_err;
      got_len     = bus.frame_len;
      bus.data_valid = 1'b0;
      bus.rx_err     = 1'b0;
   endtask

   task automatic check_model(input string tag, input bit exp_phy);
      int          n;
      logic [10:0] len;
      logic        ok, lerr;
      n    = frame_q.size();
      len  = (n > 2047) ? 11'd2047 : 11'(n);
      ok   = (n >= 4) && (ref_crc() == RESIDUE);
      lerr = (int'(len) < MIN_LEN) || (int'(len) > MAX_LEN) || (n >= 2047);
      chk({tag, "_crc_ok"},  got_ok, ok);
      chk({tag, "_len_err"}, got_len_err, lerr);
      chk({tag, "_len"},     got_len, len);
      chk({tag, "_phy"},     got_phy, exp_phy);
   endtask

   // Idle cycles with junk on the inputs: results must hold, no strobe.
   task automatic hold_check();
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         bus.frame_active = 1'b0;
         bus.data_valid   = 1'($urandom);
         bus.rx_err       = 1'($urandom);
         bus.data_in      = 8'($urandom);
         tick();
         if (bus.frame_done || bus.crc_ok !== got_ok || bus.len_err !== got_len_err ||
             bus.phy_err !== got_phy || bus.frame_len !== got_len) bad++;
      end
      bus.data_valid = 1'b0;
      bus.rx_err     = 1'b0;
      chk("hold_idle", bad, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_done"},    bus.frame_done, 0);
      chk({tag, "_crc_ok"},  bus.crc_ok, 0);
      chk({tag, "_len_err"}, bus.len_err, 0);
      chk({tag, "_phy"},     bus.phy_err, 0);
      chk({tag, "_len"},     bus.frame_len, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.data_in      = 8'h00;
      bus.data_valid   = 1'b0;
      bus.frame_active = 1'b0;
      bus.rx_err       = 1'b0;

      // Short fixed frames with hand-derived results.
      tbl[0].n = 13;
      tbl[0].b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'hFC, 8'h89, 8'h19, 8'h18};
      tbl[0].exp_ok = 1'b1; tbl[0].exp_len_err = 1'b1; tbl[0].exp_len = 11'd13;
      tbl[1].n = 0;  tbl[1].b = '{default: 8'h00};
      tbl[1].exp_ok = 1'b0; tbl[1].exp_len_err = 1'b1; tbl[1].exp_len = 11'd0;
      tbl[2].n = 3;  tbl[2].b = '{default: 8'h00};
      tbl[2].exp_ok = 1'b0; tbl[2].exp_len_err = 1'b1; tbl[2].exp_len = 11'd3;
      // Empty payload: FCS = ~0xFFFFFFFF = 0, so four zero bytes are a good frame.
      tbl[3].n = 4;  tbl[3].b = '{default: 8'h00};
      tbl[3].exp_ok = 1'b1; tbl[3].exp_len_err = 1'b1; tbl[3].exp_len = 11'd4;
      tbl[4].n = 4;  tbl[4].b = '{default: 8'hFF};
      tbl[4].exp_ok = 1'b0; tbl[4].exp_len_err = 1'b1; tbl[4].exp_len = 11'd4;

      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      foreach (tbl[t]) begin
         frame_q.delete();
         for (int i = 0; i < tbl[t].n; i++) frame_q.push_back(tbl[t].b[i]);
         send_frame(0, -1, 1'b1);
         chk($sformatf("tbl%0d_crc_ok", t),  got_ok, tbl[t].exp_ok);
         chk($sformatf("tbl%0d_len_err", t), got_len_err, tbl[t].exp_len_err);
         chk($sformatf("tbl%0d_len", t),     got_len, tbl[t].exp_len);
         chk($sformatf("tbl%0d_phy", t),     got_phy, 0);
         tick();
      end

      // 64-byte good frame with gaps, then single-bit corruption of byte 10.
      build_frame(60, 1'b1);
      send_frame(30, -1, 1'b0);
      chk("f64_crc_ok", got_ok, 1);
      chk("f64_len", got_len, 64);
      chk("f64_len_err", got_len_err, 0);
      hold_check();
      frame_q[10] = frame_q[10] ^ 8'h04;
      send_frame(30, -1, 1'b1);
      chk("f64_flip_crc_ok", got_ok, 0);
      chk("f64_flip_len", got_len, 64);
      tick();

      // Oversize and saturating lengths.
      build_frame(1596, 1'b1);
      send_frame(0, -1, 1'b0);
      chk("f1600_len", got_len, 1600);
      chk("f1600_len_err", got_len_err, 1);
      check_model("f1600", 1'b0);
      tick();
      build_frame(2096, 1'b1);
      send_frame(0, -1, 1'b0);
      chk("f2100_len", got_len, 2047);
      chk("f2100_len_err", got_len_err, 1);
      check_model("f2100", 1'b0);
      tick();

      // PHY error mid-frame, then a clean frame.
      build_frame(60, 1'b1);
      send_frame(10, 30, 1'b0);
      chk("phy_crc_ok", got_ok, 1);
      chk("phy_set", got_phy, 1);
      tick();
      build_frame(60, 1'b1);
      send_frame(10, -1, 1'b0);
      chk("phy_clear", got_phy, 0);
      chk("phy_clear_crc_ok", got_ok, 1);
      tick();

      // Back-to-back frames with exactly one idle cycle between them.
      build_frame(60, 1'b1);
      send_frame(0, -1, 1'b0);
      chk("b2b_a_crc_ok", got_ok, 1);
      build_frame(70, 1'b1);
      send_frame(0, -1, 1'b0);
      chk("b2b_b_crc_ok", got_ok, 1);
      chk("b2b_b_len", got_len, 74);
      tick();

      // Reset in the middle of a frame: no strobe, results cleared.
      build_frame(60, 1'b1);
      bus.frame_active = 1'b1;
      for (int i = 0; i < 30; i++) begin
         bus.data_valid = 1'b1;
         bus.data_in    = frame_q[i];
         tick();
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      bus.frame_active = 1'b0;
      bus.data_valid   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.frame_done) seen++;
         end
         chk("midrst_no_done", seen, 0);
      end
      build_frame(60, 1'b1);
      send_frame(20, -1, 1'b0);
      chk("after_rst_crc_ok", got_ok, 1);
      chk("after_rst_len", got_len, 64);
      tick();

      // Random frames against the reference model.
      for (int r = 0; r < 10; r++) begin
         int nd, ei;
         bit good;
         nd   = $urandom_range(0, 120);
         good = 1'($urandom);
         build_frame(nd, good);
         ei   = ($urandom_range(3) == 0) ? $urandom_range(0, nd + 3) : -1;
         send_frame(25, ei, 1'($urandom));
         check_model($sformatf("rnd%0d", r), ei >= 0);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
